// File: rtl/alu_arbiter.sv
// Two-master valid/ready arbiter and sequencer for the shared 8-bit ALU.
// Define ALU_ARB_RR_EN for round-robin contention; default is fixed priority to master 0.
module alu_arbiter (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [3:0] req0_op,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [3:0] req1_op,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic       rsp_id,
   output logic [7:0] rsp_data,
   output logic [3:0] rsp_flags,
   output logic       rsp_err,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_s,
   input  logic [7:0] alu_out,
   input  logic       alu_z,
   input  logic       alu_n,
   input  logic       alu_c,
   input  logic       alu_v
);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e     state_q, state_d;
   logic [3:0] op_q;
   logic [7:0] a_q, b_q;
   logic       id_q;
   logic       last_grant_q;
   logic       rsp_id_q;
   logic [7:0] rsp_data_q;
   logic [3:0] rsp_flags_q;
   logic       rsp_err_q;
   logic       accept;
   logic       grant1;

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      grant1     = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (rst_n && (req0_valid || req1_valid)) begin
               accept = 1'b1;
               if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
                  grant1 = ~last_grant_q;
`else
                  grant1 = 1'b0;
`endif
               end else begin
                  grant1 = req1_valid;
               end
               req0_ready = ~grant1;
               req1_ready = grant1;
               state_d    = StExec;
            end
         end
         StExec: state_d = StResp;
         StResp: begin
            if (rsp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         op_q         <= 4'h0;
         a_q          <= 8'h00;
         b_q          <= 8'h00;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= 8'h00;
         rsp_flags_q  <= 4'h0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q         <= grant1 ? req1_op : req0_op;
            a_q          <= grant1 ? req1_a : req0_a;
            b_q          <= grant1 ? req1_b : req0_b;
            id_q         <= grant1;
            last_grant_q <= grant1;
         end
         if (state_q == StExec) begin
            rsp_id_q <= id_q;
            // Opcodes above 0x8 are not issued; the ALU result is discarded.
            if (op_q <= 4'h8) begin
               rsp_data_q  <= alu_out;
               rsp_flags_q <= {alu_z, alu_n, alu_c, alu_v};
               rsp_err_q   <= 1'b0;
            end else begin
               rsp_data_q  <= 8'h00;
               rsp_flags_q <= 4'h0;
               rsp_err_q   <= 1'b1;
            end
         end
      end
   end

   assign alu_a     = a_q;
   assign alu_b     = b_q;
   assign alu_s     = op_q;
   assign rsp_valid = (state_q == StResp);
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_flags = rsp_flags_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req0_ready, req1_valid, req1_ready;
   logic [3:0] req0_op, req1_op;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic       rsp_valid, rsp_ready, rsp_id, rsp_err;
   logic [7:0] rsp_data;
   logic [3:0] rsp_flags;
   logic [7:0] alu_a, alu_b, alu_out;
   logic [3:0] alu_s;
   logic       alu_z, alu_n, alu_c, alu_v;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_out(alu_out),
      .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c), .alu_v(alu_v)
   );

   // Shared ALU: add, subtract with borrow; anything else gives a ^ b with C/V forced high.
   always_comb begin
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_out = 8'h00;
      case (alu_s)
         4'h0: begin
            {alu_c, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            alu_v = (alu_a[7] == alu_b[7]) && (alu_out[7] != alu_a[7]);
         end
         4'h1: begin
            {alu_c, alu_out} = {1'b0, alu_a} - {1'b0, alu_b};
            alu_v = (alu_a[7] != alu_b[7]) && (alu_out[7] != alu_a[7]);
         end
         default: begin
            alu_out = alu_a ^ alu_b;
            alu_c   = 1'b1;
            alu_v   = 1'b1;
         end
      endcase
      alu_z = (alu_out == 8'h00);
      alu_n = alu_out[7];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rsp(input string tag, input logic id, input logic [7:0] data,
                            input logic [3:0] flags, input logic err);
      check_eq({tag, "_valid"}, rsp_valid, 1'b1);
      check_eq({tag, "_id"}, rsp_id, id);
      check_eq({tag, "_data"}, rsp_data, data);
      check_eq({tag, "_flags"}, rsp_flags, flags);
      check_eq({tag, "_err"}, rsp_err, err);
   endtask

   initial begin
      logic exp_id;
      rst_n = 1'b0;      rsp_ready = 1'b1;
      req0_valid = 1'b0; req0_op = 4'h0; req0_a = 8'h7F; req0_b = 8'h01;
      req1_valid = 1'b0; req1_op = 4'h1; req1_a = 8'h00; req1_b = 8'h01;
      step();
      step();

      // Reset state, readies held low even with both valids up
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check_eq("rst_rdy0", req0_ready, 1'b0);
      check_eq("rst_rdy1", req1_ready, 1'b0);
      check_eq("rst_rsp_valid", rsp_valid, 1'b0);
      check_eq("rst_rsp_id", rsp_id, 1'b0);
      check_eq("rst_rsp_data", rsp_data, 8'h00);
      check_eq("rst_rsp_flags", rsp_flags, 4'h0);
      check_eq("rst_rsp_err", rsp_err, 1'b0);
      check_eq("rst_alu", {alu_a, alu_b, alu_s}, 20'h0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst_n = 1'b1;
      step();

      // Single add: 0x7F + 0x01
      req0_valid = 1'b1;
      #1;
      check_eq("add_rdy0", req0_ready, 1'b1);
      check_eq("add_rdy1", req1_ready, 1'b0);
      step();
      req0_valid = 1'b0;
      #1;
      check_eq("add_exec_alu", {alu_a, alu_b, alu_s}, {8'h7F, 8'h01, 4'h0});
      check_eq("add_exec_nvalid", rsp_valid, 1'b0);
      step();
      check_rsp("add", 1'b0, 8'h80, 4'b0101, 1'b0);
      step();

      // Subtract with borrow from master 1
      req1_valid = 1'b1;
      #1;
      check_eq("sub_rdy1", req1_ready, 1'b1);
      check_eq("sub_rdy0", req0_ready, 1'b0);
      step();
      req1_valid = 1'b0;
      step();
      check_rsp("sub", 1'b1, 8'hFF, 4'b0110, 1'b0);
      step();

      // Contention: four back-to-back transactions
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
         exp_id = (i % 2) == 1;
`else
         exp_id = 1'b0;
`endif
         #1;
         check_eq("cont_rdy0", req0_ready, !exp_id);
         check_eq("cont_rdy1", req1_ready, exp_id);
         step();
         check_eq("cont_exec_rdy", {req0_ready, req1_ready}, 2'b00);
         step();
         check_rsp("cont", exp_id, exp_id ? 8'hFF : 8'h80, exp_id ? 4'b0110 : 4'b0101, 1'b0);
         step();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Backpressure: 1 + 1 held for five cycles in RESP
      req0_a = 8'h01; req0_b = 8'h01; rsp_ready = 1'b0;
      req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
      step();
      req1_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check_rsp("bp", 1'b0, 8'h02, 4'b0000, 1'b0);
         check_eq("bp_rdy", {req0_ready, req1_ready}, 2'b00);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      check_eq("bp_release_valid", rsp_valid, 1'b1);
      step();
      check_eq("bp_done_valid", rsp_valid, 1'b0);
      check_eq("bp_next_rdy1", req1_ready, 1'b1);
      step();
      req1_valid = 1'b0;
      step();
      check_rsp("bp_next", 1'b1, 8'hFF, 4'b0110, 1'b0);
      step();

      // Illegal opcode
      req0_op = 4'hC; req0_a = 8'h12; req0_b = 8'h34;
      req0_valid = 1'b1;
      #1;
      check_eq("ill_rdy0", req0_ready, 1'b1);
      step();
      req0_valid = 1'b0;
      #1;
      check_eq("ill_exec_nvalid", rsp_valid, 1'b0);
      step();
      check_rsp("ill", 1'b0, 8'h00, 4'h0, 1'b1);
      step();

      // Reset during RESP after a master 0 grant
      req0_op = 4'h0; req0_a = 8'h7F; req0_b = 8'h01; rsp_ready = 1'b0;
      req0_valid = 1'b1;
      step();
      req0_valid = 1'b0;
      step();
      check_eq("rr_pre_valid", rsp_valid, 1'b1);
      rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check_eq("rr_in_rst_rdy", {req0_ready, req1_ready}, 2'b00);
      step();
      rst_n = 1'b1;
      #1;
      check_eq("rr_post_valid", rsp_valid, 1'b0);
      check_eq("rr_post_alu", {alu_a, alu_b, alu_s}, 20'h0);
      check_eq("rr_post_data", rsp_data, 8'h00);
      check_eq("rr_post_rdy0", req0_ready, 1'b1);
      check_eq("rr_post_rdy1", req1_ready, 1'b0);
      rsp_ready = 1'b1;
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      step();
      check_rsp("rr_after", 1'b0, 8'h80, 4'b0101, 1'b0);
      step();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port request arbiter and sequencer for the shared 8-bit combinational ALU. It accepts operation requests from two independent masters over valid/ready handshakes and selects one winner per transaction. It drives the winner's latched operands and opcode into the ALU, registers the result and Z/N/C/V flags, and returns them on a single tagged response channel. It sits between the control units and the ALU instance, and is the only block allowed to drive the ALU's `a`, `b` and `s` inputs.

## Interface
Parameters:
- none. Data width is fixed at 8 and opcode width at 4, matching the ALU.

Ports:
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req0_valid` in 1: master 0 has a request.
- `req0_ready` out 1: master 0 request accepted this cycle.
- `req0_op` in 4: ALU opcode.
- `req0_a`, `req0_b` in 8 each: operands.
- `req1_valid`, `req1_ready`, `req1_op`, `req1_a`, `req1_b`: same as the master 0 ports, for master 1.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: requester index of the response.
- `rsp_data` out 8: ALU result.
- `rsp_flags` out 4: {Z,N,C,V}.
- `rsp_err` out 1: illegal opcode; the request was not issued.
- `alu_a`, `alu_b` out 8 each: ALU operand drive.
- `alu_s` out 4: ALU opcode drive.
- `alu_out` in 8: ALU result.
- `alu_z`, `alu_n`, `alu_c`, `alu_v` in 1 each: ALU flags.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - If neither valid is high, stay in IDLE.
  - Otherwise select a winner (see the grant rules below).
  - Assert `reqN_ready` for the winner only, combinationally, in this cycle.
  - Latch `op`, `a`, `b` and the winner index into the operand registers, then go to EXEC.
  - The loser's ready stays 0; its request must be held stable until accepted.
- **EXEC**
  - `alu_a`, `alu_b` and `alu_s` come from the operand registers. They are always driven from these registers, so they stay stable outside EXEC.
  - If the opcode is 0x0–0x8, capture `alu_out` into `rsp_data`, {`alu_z`,`alu_n`,`alu_c`,`alu_v`} into `rsp_flags`, and set `rsp_err`=0.
  - If the opcode is 0x9–0xF, set `rsp_data`=0x00, `rsp_flags`=0 and `rsp_err`=1. `alu_out` is ignored.
  - Go to RESP.
- **RESP**
  - `rsp_valid`=1.
  - `rsp_id`, `rsp_data`, `rsp_flags` and `rsp_err` are held stable until `rsp_ready`=1.
  - On `rsp_valid` && `rsp_ready`, go to IDLE.
  - No request is accepted in RESP.
- **Grant rules**
  - Only one valid: that requester wins.
  - Both valid: resolved by the policy selected in Configuration.
  - `last_grant` updates only on an accepted request.
- **Reset**
  - Reset while in EXEC or RESP aborts the in-flight operation. No response is produced.
  - Reset values: FSM = IDLE; `req0_ready` = `req1_ready` = 0; `rsp_valid` = 0; `rsp_id` = 0; `rsp_data` = 0x00; `rsp_flags` = 0; `rsp_err` = 0; `alu_a` = `alu_b` = 0x00; `alu_s` = 0x0; `last_grant` = 1, so master 0 wins the first contention.
- Ready outputs are 0 whenever `rst_n`=0.

## Timing
- Accept in cycle T (valid && ready).
- ALU drive is valid in T+1 (EXEC).
- `rsp_valid` rises in T+2.
- Minimum request-to-request spacing is 3 cycles, with `rsp_ready` held high.
- Each cycle of `rsp_ready`=0 in RESP adds one cycle.
- The ALU combinational path (operand register → ALU → result register) must close within one cycle.
- `reqN_ready` depends combinationally on both `reqN_valid` inputs and on FSM state. There is no combinational path from the `rsp_*` inputs to the `req*` outputs.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin. On contention the requester not equal to `last_grant` wins, so continuous requests from both masters alternate 0,1,0,1…
- `ALU_ARB_RR_EN` undefined: fixed priority. Master 0 always wins contention. `last_grant` is still maintained but does not affect selection.

## Test plan
- **Single add:** req0 op=0x0, a=0x7F, b=0x01 → `req0_ready` in T, `rsp_valid` in T+2, `rsp_id`=0, `rsp_data`=0x80, `rsp_flags`=0b0101 (Z0 N1 C0 V1), `rsp_err`=0.
- **Subtract with borrow:** req1 op=0x1, a=0x00, b=0x01 → `rsp_id`=1, `rsp_data`=0xFF, `rsp_flags`=0b0110 (N1 C1).
- **Contention:** both valid continuously for 4 transactions. With `ALU_ARB_RR_EN` the ids are 0,1,0,1. Without it they are 0,0,0,0, and `req1_ready` never asserts.
- **Backpressure:** `rsp_ready`=0 for 5 cycles in RESP → response fields stable throughout, no `reqN_ready` asserted, and the response completes on the first `rsp_ready`=1.
- **Illegal opcode:** req0 op=0xC, a=0x12, b=0x34 → `rsp_err`=1, `rsp_data`=0x00, `rsp_flags`=0, latency unchanged at T+2.
- **Reset mid-operation:** `rst_n`=0 for one cycle during RESP → next cycle `rsp_valid`=0, FSM in IDLE, `alu_a`/`alu_b`/`alu_s` = 0. With both requests valid afterward, master 0 wins first.
